// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: one Booth step per clock over a
// (WIDTH+2)-bit extended multiplier, signed or unsigned per operation.
module booth_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int AW   = WIDTH + 3;
    localparam int MW   = WIDTH + 2;
    localparam int CW   = $clog2(ITER + 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
            $error("booth_seq_multiplier: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        x_q, x_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [MW-1:0]        mq_q, mq_d;
    logic                 prev_q, prev_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [2:0]           trip;
    logic [AW-1:0]        sel;
    logic [AW-1:0]        sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    // Booth digit select from {y[2i+1], y[2i], y[2i-1]}
    always_comb begin
        trip = {mq_q[1], mq_q[0], prev_q};
        sel  = '0;
        case (trip)
            3'b001, 3'b010: sel = x_q;
            3'b011:         sel = {x_q[AW-2:0], 1'b0};
            3'b100:         sel = -{x_q[AW-2:0], 1'b0};
            3'b101, 3'b110: sel = -x_q;
            default:        sel = '0;
        endcase
        sum = acc_q + sel;
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_BUSY;
                    x_d     = in_signed ? {{3{x[WIDTH-1]}}, x} : {3'b000, x};
                    mq_d    = in_signed ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};
                    acc_d   = '0;
                    prev_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(ITER)) begin
                    // all multiplier bits shifted out: low 2*WIDTH bits of {acc, mq}
                    prod_d  = {acc_q[WIDTH-3:0], mq_q};
                    state_d = S_DONE;
                end else begin
                    acc_d  = {{2{sum[AW-1]}}, sum[AW-1:2]};
                    mq_d   = {sum[1:0], mq_q[MW-1:2]};
                    prev_d = mq_q[1];
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (abort || out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign product   = prod_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed and random checks of booth_seq_multiplier at WIDTH=32.
module tb_booth_seq_multiplier;

    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           in_signed;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           abort;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    int errors = 0;
    int checks = 0;

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .x         (x),
        .y         (y),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   vx;
        logic [W-1:0]   vy;
        logic           vs;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] ax, input logic [W-1:0] ay, input logic as);
        @(negedge clk);
        x = ax; y = ay; in_signed = as; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x = $urandom; y = $urandom; in_signed = $urandom_range(0, 1);
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (out_valid) break;
        end
        if (!out_valid) edges = -1;
    endtask

    task automatic accept();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [63:0] ref_p;
        logic [63:0] prev_p;
        logic [W-1:0] rx, ry;
        logic rs;
        logic seen;

        vecs[0] = '{32'd2,         32'hFFFF_FFFB, 1'b1, 64'hFFFF_FFFF_FFFF_FFF6};
        vecs[1] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
        vecs[5] = '{32'd12,        32'd5,         1'b0, 64'd60};
        vecs[6] = '{32'hFFFF_FFEC, 32'hFFFF_FFF5, 1'b1, 64'd220};
        vecs[7] = '{32'd0,         32'hFFFF_FFFF, 1'b0, 64'd0};
        vecs[8] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h7FFF_FFFF_8000_0000};
        vecs[9] = '{32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000};

        rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; x = '0; y = '0;
        abort = 1'b0; out_ready = 1'b0;
        #12;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].vx, vecs[i].vy, vecs[i].vs);
            check($sformatf("vec%0d busy", i), 64'(busy), 64'd1);
            wait_done(lat);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd18);
            check($sformatf("vec%0d product", i), product, vecs[i].exp);
            accept();
            check($sformatf("vec%0d idle", i), 64'(in_ready), 64'd1);
        end

        // backpressure: result and handshake held while out_ready stays low
        start_op(32'd12, 32'd5, 1'b0);
        wait_done(lat);
        check("bp latency", 64'(lat), 64'd18);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp out_valid held", 64'(out_valid), 64'd1);
            check("bp product held", product, 64'd60);
            check("bp in_ready low", 64'(in_ready), 64'd0);
        end
        accept();
        check("bp released out_valid", 64'(out_valid), 64'd0);
        check("bp released in_ready", 64'(in_ready), 64'd1);

        // abort in BUSY cycle 5
        prev_p = product;
        start_op(32'd1000, 32'd3, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort in_ready", 64'(in_ready), 64'd1);
        check("abort busy", 64'(busy), 64'd0);
        check("abort product kept", product, prev_p);
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort no out_valid", 64'(seen), 64'd0);

        // abort while DONE discards the result without a handshake
        start_op(32'd7, 32'd9, 1'b0);
        wait_done(lat);
        check("done product", product, 64'd63);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort done out_valid", 64'(out_valid), 64'd0);
        check("abort done in_ready", 64'(in_ready), 64'd1);

        // abort together with in_valid in IDLE still accepts
        @(negedge clk);
        x = 32'd6; y = 32'd7; in_signed = 1'b0; in_valid = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; abort = 1'b0;
        check("idle abort accepted", 64'(busy), 64'd1);
        wait_done(lat);
        check("idle abort latency", 64'(lat), 64'd18);
        check("idle abort product", product, 64'd42);
        accept();

        // asynchronous reset mid-BUSY
        start_op(32'd100, 32'd100, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst in_ready", 64'(in_ready), 64'd1);
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("post rst no out_valid", 64'(seen), 64'd0);
        start_op(32'hFFFF_FFEC, 32'hFFFF_FFF5, 1'b1);
        wait_done(lat);
        check("post rst latency", 64'(lat), 64'd18);
        check("post rst product", product, 64'd220);
        accept();

        // random operands with random consumer stalls
        for (int n = 0; n < 1200; n++) begin
            rx = $urandom; ry = $urandom; rs = $urandom_range(0, 1);
            if (rs) ref_p = $signed({{W{rx[W-1]}}, rx}) * $signed({{W{ry[W-1]}}, ry});
            else    ref_p = {{W{1'b0}}, rx} * {{W{1'b0}}, ry};
            start_op(rx, ry, rs);
            wait_done(lat);
            if (lat != 18) check("rand latency", 64'(lat), 64'd18);
            check($sformatf("rand %h*%h s=%0d", rx, ry, rs), product, ref_p);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            accept();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
